// File: rtl/temp_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : temp_sample_sequencer
// Purpose  : Periodic ADC burst sampler. Averages 2^AVG_LOG2 samples per
//            burst and feeds the average plus frozen calibration constants
//            to the combinational temperature calculator, then registers
//            the calculator result with a one-cycle valid pulse.
// Options  : define TEMP_ALARM_EN to add hi/lo threshold alarm outputs.
// Revision : 1.0 - initial release
// ============================================================================
module temp_sample_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int PERIOD_W      = 16,
    parameter int AVG_LOG2      = 2,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [31:0] cfg_tc_base,
    input  logic [7:0]  cfg_tc_ref,
`ifdef TEMP_ALARM_EN
    input  logic [31:0] cfg_hi_thr,
    input  logic [31:0] cfg_lo_thr,
    output logic        alarm_hi,
    output logic        alarm_lo,
`endif
    output logic        adc_req,
    input  logic        adc_ack,
    input  logic [15:0] adc_data_in,
    output logic [31:0] calc_tc_base,
    output logic [7:0]  calc_tc_ref,
    output logic [15:0] calc_adc_data,
    input  logic [31:0] calc_tempc,
    output logic [31:0] temp_out,
    output logic        temp_valid,
    output logic        busy,
    output logic        adc_timeout
);

    // Accumulator is wide enough for a full burst of 16-bit samples.
    localparam int c_acc_w  = 16 + AVG_LOG2;
    localparam int c_scnt_w = AVG_LOG2 + 1;
    localparam int c_to_w   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [PERIOD_W-1:0] c_reload    = PERIOD_W'(SAMPLE_PERIOD - 1);
    localparam logic [PERIOD_W-1:0] c_cnt_one   = PERIOD_W'(1);
    localparam logic [c_scnt_w-1:0] c_last_samp = c_scnt_w'((1 << AVG_LOG2) - 1);
    localparam logic [c_scnt_w-1:0] c_scnt_one  = c_scnt_w'(1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(ACK_TIMEOUT - 1);
    localparam logic [c_to_w-1:0]   c_to_one    = c_to_w'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_GAP  = 3'd3,
        S_CALC = 3'd4
    } state_t;

    state_t              state_q,      state_d;
    logic [PERIOD_W-1:0] cnt_q,        cnt_d;
    logic [c_acc_w-1:0]  acc_q,        acc_d;
    logic [c_scnt_w-1:0] scnt_q,       scnt_d;
    logic [c_to_w-1:0]   to_q,         to_d;
    logic [31:0]         base_sh_q,    base_sh_d;
    logic [7:0]          ref_sh_q,     ref_sh_d;
    logic [31:0]         calc_base_q,  calc_base_d;
    logic [7:0]          calc_ref_q,   calc_ref_d;
    logic [15:0]         calc_adc_q,   calc_adc_d;
    logic [31:0]         temp_out_q,   temp_out_d;
    logic                temp_valid_q, temp_valid_d;
    logic                timeout_q,    timeout_d;
`ifdef TEMP_ALARM_EN
    logic [31:0]         hi_sh_q,      hi_sh_d;
    logic [31:0]         lo_sh_q,      lo_sh_d;
    logic                alarm_hi_q,   alarm_hi_d;
    logic                alarm_lo_q,   alarm_lo_d;
`endif

    logic [c_acc_w-1:0]  w_sum;
    logic [15:0]         w_avg;
    logic [PERIOD_W-1:0] w_cnt_run;

    assign w_sum     = acc_q + c_acc_w'(adc_data_in);
    assign w_avg     = 16'(w_sum >> AVG_LOG2);
    // Outside WAIT the period counter parks at zero so an expired period
    // is remembered as a single pending burst start.
    assign w_cnt_run = (cnt_q == '0) ? '0 : (cnt_q - c_cnt_one);

    // Next-state, datapath and pulse generation for the burst sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        scnt_d       = scnt_q;
        to_d         = '0;
        base_sh_d    = cfg_we ? cfg_tc_base : base_sh_q;
        ref_sh_d     = cfg_we ? cfg_tc_ref  : ref_sh_q;
        calc_base_d  = calc_base_q;
        calc_ref_d   = calc_ref_q;
        calc_adc_d   = calc_adc_q;
        temp_out_d   = temp_out_q;
        temp_valid_d = 1'b0;
        timeout_d    = 1'b0;
`ifdef TEMP_ALARM_EN
        hi_sh_d      = cfg_we ? cfg_hi_thr : hi_sh_q;
        lo_sh_d      = cfg_we ? cfg_lo_thr : lo_sh_q;
        alarm_hi_d   = alarm_hi_q;
        alarm_lo_d   = alarm_lo_q;
`endif
        if (!enable) begin
            // Abort: drop the burst, keep the last published results.
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        // Burst start: freeze calibration, write-through
                        // of a same-cycle configuration update.
                        state_d     = S_REQ;
                        cnt_d       = c_reload;
                        calc_base_d = base_sh_d;
                        calc_ref_d  = ref_sh_d;
                    end else begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
                S_REQ: begin
                    cnt_d = w_cnt_run;
                    if (adc_ack) begin
                        if (scnt_q == c_last_samp) begin
                            state_d    = S_CALC;
                            calc_adc_d = w_avg;
                            acc_d      = '0;
                            scnt_d     = '0;
                        end else begin
                            state_d = S_GAP;
                            acc_d   = w_sum;
                            scnt_d  = scnt_q + c_scnt_one;
                        end
                    end else if (to_q == c_to_last) begin
                        state_d   = S_WAIT;
                        timeout_d = 1'b1;
                        acc_d     = '0;
                        scnt_d    = '0;
                    end else begin
                        to_d = to_q + c_to_one;
                    end
                end
                S_GAP: begin
                    cnt_d   = w_cnt_run;
                    state_d = S_REQ;
                end
                S_CALC: begin
                    // Calculator inputs have settled for one cycle.
                    cnt_d        = w_cnt_run;
                    temp_out_d   = calc_tempc;
                    temp_valid_d = 1'b1;
`ifdef TEMP_ALARM_EN
                    alarm_hi_d   = (calc_tempc > hi_sh_q);
                    alarm_lo_d   = (calc_tempc < lo_sh_q);
`endif
                    state_d      = S_WAIT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            scnt_q       <= '0;
            to_q         <= '0;
            base_sh_q    <= '0;
            ref_sh_q     <= '0;
            calc_base_q  <= '0;
            calc_ref_q   <= '0;
            calc_adc_q   <= '0;
            temp_out_q   <= '0;
            temp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef TEMP_ALARM_EN
            hi_sh_q      <= '0;
            lo_sh_q      <= '0;
            alarm_hi_q   <= 1'b0;
            alarm_lo_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            scnt_q       <= scnt_d;
            to_q         <= to_d;
            base_sh_q    <= base_sh_d;
            ref_sh_q     <= ref_sh_d;
            calc_base_q  <= calc_base_d;
            calc_ref_q   <= calc_ref_d;
            calc_adc_q   <= calc_adc_d;
            temp_out_q   <= temp_out_d;
            temp_valid_q <= temp_valid_d;
            timeout_q    <= timeout_d;
`ifdef TEMP_ALARM_EN
            hi_sh_q      <= hi_sh_d;
            lo_sh_q      <= lo_sh_d;
            alarm_hi_q   <= alarm_hi_d;
            alarm_lo_q   <= alarm_lo_d;
`endif
        end
    end

    assign adc_req       = (state_q == S_REQ);
    assign busy          = (state_q == S_REQ) || (state_q == S_GAP) || (state_q == S_CALC);
    assign calc_tc_base  = calc_base_q;
    assign calc_tc_ref   = calc_ref_q;
    assign calc_adc_data = calc_adc_q;
    assign temp_out      = temp_out_q;
    assign temp_valid    = temp_valid_q;
    assign adc_timeout   = timeout_q;
`ifdef TEMP_ALARM_EN
    assign alarm_hi      = alarm_hi_q;
    assign alarm_lo      = alarm_lo_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_temp_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_sample_sequencer
// Purpose  : Self-checking bench for temp_sample_sequencer with an ADC
//            responder, a calculator model and a burst-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_sample_sequencer;

    localparam int SP        = 20;
    localparam int PW        = 16;
    localparam int AL        = 2;
    localparam int TO        = 64;
    localparam int NS        = 4;
    localparam int ACK_DELAY = 3;

    localparam int PH_OFF  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_REQ  = 2;
    localparam int PH_GAP  = 3;
    localparam int PH_CALC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_tc_base = '0;
    logic [7:0]  cfg_tc_ref = '0;
    logic        adc_req;
    logic        adc_ack;
    logic [15:0] adc_data_in;
    logic [31:0] calc_tc_base;
    logic [7:0]  calc_tc_ref;
    logic [15:0] calc_adc_data;
    logic [31:0] calc_tempc;
    logic [31:0] temp_out;
    logic        temp_valid;
    logic        busy;
    logic        adc_timeout;
`ifdef TEMP_ALARM_EN
    logic [31:0] cfg_hi_thr = '0;
    logic [31:0] cfg_lo_thr = '0;
    logic        alarm_hi;
    logic        alarm_lo;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // ADC responder controls
    logic        ack_en = 1'b1;
    logic        stray_req = 1'b0;
    logic [15:0] samp_vals [4];

    // Reference model state
    int          m_k = 0;
    int          m_ph = PH_OFF;
    int          m_start_at = 0;
    int          m_nack = 0;
    logic [15:0] m_samps [$];
    logic [31:0] m_base_sh = '0;
    logic [7:0]  m_ref_sh = '0;
    logic        e_valid = 1'b0;
    logic        e_tout = 1'b0;
    logic [15:0] e_adc = '0;
    logic [31:0] e_base = '0;
    logic [7:0]  e_ref = '0;
    logic [31:0] e_temp = '0;
`ifdef TEMP_ALARM_EN
    logic [31:0] m_hi_sh = '0;
    logic [31:0] m_lo_sh = '0;
    logic        e_ahi = 1'b0;
    logic        e_alo = 1'b0;
`endif

    // Combinational temperature calculator stand-in
    assign calc_tempc = 32'(calc_adc_data) + calc_tc_base;

    always #5 clk = ~clk;

    temp_sample_sequencer #(
        .SAMPLE_PERIOD(SP),
        .PERIOD_W     (PW),
        .AVG_LOG2     (AL),
        .ACK_TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_tc_base  (cfg_tc_base),
        .cfg_tc_ref   (cfg_tc_ref),
`ifdef TEMP_ALARM_EN
        .cfg_hi_thr   (cfg_hi_thr),
        .cfg_lo_thr   (cfg_lo_thr),
        .alarm_hi     (alarm_hi),
        .alarm_lo     (alarm_lo),
`endif
        .adc_req      (adc_req),
        .adc_ack      (adc_ack),
        .adc_data_in  (adc_data_in),
        .calc_tc_base (calc_tc_base),
        .calc_tc_ref  (calc_tc_ref),
        .calc_adc_data(calc_adc_data),
        .calc_tempc   (calc_tempc),
        .temp_out     (temp_out),
        .temp_valid   (temp_valid),
        .busy         (busy),
        .adc_timeout  (adc_timeout)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t: got no event, expected one within bound", nm, $time);
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (temp_valid) got = 1'b1;
        end
        if (!got) bound_fail(nm);
    endtask

    task automatic wait_tout(input int maxc, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (adc_timeout) got = 1'b1;
        end
        if (!got) bound_fail(nm);
    endtask

    task automatic wait_req_rise(input int maxc, input string nm);
        bit got = 1'b0;
        bit prev;
        prev = adc_req;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (adc_req && !prev) got = 1'b1;
            prev = adc_req;
        end
        if (!got) bound_fail(nm);
    endtask

    // Reference model: burst-level behaviour advanced once per clock edge.
    task automatic model_step();
        int sum;
        m_k++;
        e_valid = 1'b0;
        e_tout  = 1'b0;
        if (!enable) begin
            m_ph = PH_OFF;
            m_samps.delete();
            m_nack = 0;
        end else begin
            case (m_ph)
                PH_OFF: begin
                    m_ph       = PH_WAIT;
                    m_start_at = m_k + 1;
                end
                PH_WAIT: begin
                    // A burst begins on the period grid, or as soon as
                    // possible if the grid point already passed.
                    if (m_k >= m_start_at) begin
                        m_ph       = PH_REQ;
                        m_start_at = m_k + SP;
                        m_nack     = 0;
                        e_base     = cfg_we ? cfg_tc_base : m_base_sh;
                        e_ref      = cfg_we ? cfg_tc_ref  : m_ref_sh;
                    end
                end
                PH_REQ: begin
                    if (adc_ack) begin
                        m_samps.push_back(adc_data_in);
                        m_nack = 0;
                        if (m_samps.size() == NS) begin
                            sum = 0;
                            foreach (m_samps[i]) sum += int'(m_samps[i]);
                            e_adc = 16'(sum / NS);
                            m_samps.delete();
                            m_ph = PH_CALC;
                        end else begin
                            m_ph = PH_GAP;
                        end
                    end else begin
                        m_nack++;
                        if (m_nack == TO) begin
                            e_tout = 1'b1;
                            m_nack = 0;
                            m_samps.delete();
                            m_ph = PH_WAIT;
                        end
                    end
                end
                PH_GAP: m_ph = PH_REQ;
                default: begin
                    e_temp  = 32'(e_adc) + e_base;
                    e_valid = 1'b1;
`ifdef TEMP_ALARM_EN
                    e_ahi   = (e_temp > m_hi_sh);
                    e_alo   = (e_temp < m_lo_sh);
`endif
                    m_ph    = PH_WAIT;
                end
            endcase
        end
        if (cfg_we) begin
            m_base_sh = cfg_tc_base;
            m_ref_sh  = cfg_tc_ref;
`ifdef TEMP_ALARM_EN
            m_hi_sh   = cfg_hi_thr;
            m_lo_sh   = cfg_lo_thr;
`endif
        end
    endtask

    task automatic model_reset();
        m_ph = PH_OFF; m_nack = 0; m_samps.delete();
        m_base_sh = '0; m_ref_sh = '0;
        e_valid = 1'b0; e_tout = 1'b0; e_adc = '0; e_base = '0; e_ref = '0; e_temp = '0;
`ifdef TEMP_ALARM_EN
        m_hi_sh = '0; m_lo_sh = '0; e_ahi = 1'b0; e_alo = 1'b0;
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare process: every output against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cmp("adc_req",       32'(adc_req),     32'(m_ph == PH_REQ));
            cmp("busy",          32'(busy),        32'(m_ph == PH_REQ || m_ph == PH_GAP || m_ph == PH_CALC));
            cmp("temp_valid",    32'(temp_valid),  32'(e_valid));
            cmp("adc_timeout",   32'(adc_timeout), 32'(e_tout));
            cmp("temp_out",      temp_out,         e_temp);
            cmp("calc_adc_data", 32'(calc_adc_data), 32'(e_adc));
            cmp("calc_tc_base",  calc_tc_base,     e_base);
            cmp("calc_tc_ref",   32'(calc_tc_ref), 32'(e_ref));
`ifdef TEMP_ALARM_EN
            cmp("alarm_hi",      32'(alarm_hi),    32'(e_ahi));
            cmp("alarm_lo",      32'(alarm_lo),    32'(e_alo));
`endif
        end
    end

    // ADC responder: acks on the third cycle of each request.
    initial begin
        int rwait;
        int rlow;
        int ridx;
        rwait = 0; rlow = 0; ridx = 0;
        adc_ack = 1'b0;
        adc_data_in = '0;
        forever begin
            @(negedge clk);
            adc_ack = 1'b0;
            if (stray_req) begin
                adc_ack     = 1'b1;
                adc_data_in = 16'hFFFF;
            end else if (adc_req) begin
                rlow = 0;
                rwait++;
                if (ack_en && rwait == ACK_DELAY) begin
                    adc_ack     = 1'b1;
                    adc_data_in = samp_vals[ridx];
                    ridx        = (ridx + 1) % NS;
                    rwait       = 0;
                end
            end else begin
                rwait = 0;
                rlow++;
                if (rlow >= 2) ridx = 0;
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        int n;
        samp_vals = '{16'd100, 16'd101, 16'd102, 16'd103};
        repeat (3) @(negedge clk);
        cmp("reset temp_out", temp_out, 32'd0);
        cmp("reset adc_req", 32'(adc_req), 32'd0);
        cmp("reset busy", 32'(busy), 32'd0);
        cmp("reset calc_tc_base", calc_tc_base, 32'd0);
        @(posedge clk) #3 rst_n = 1'b1;

        @(negedge clk);
        cfg_we = 1'b1; cfg_tc_base = 32'd1; cfg_tc_ref = 8'h25;
`ifdef TEMP_ALARM_EN
        cfg_hi_thr = 32'd100; cfg_lo_thr = 32'd0;
`endif
        @(negedge clk);
        cfg_we = 1'b0;
        enable = 1'b1;

        // Basic averaging and period
        wait_valid(100, "first burst valid");
        cmp("first avg", 32'(calc_adc_data), 32'd101);
        cmp("first temp", temp_out, 32'd102);
        cmp("first tc_ref", 32'(calc_tc_ref), 32'h25);
`ifdef TEMP_ALARM_EN
        cmp("alarm_hi above thr", 32'(alarm_hi), 32'd1);
`endif
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (temp_valid) n++;
        end
        cmp("valid pulses in 60 cycles", 32'(n), 32'd3);

        // Full-scale samples
        samp_vals = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        wait_valid(40, "full-scale valid");
        cmp("full-scale avg", 32'(calc_adc_data), 32'h0000FFFF);
        cmp("full-scale temp", temp_out, 32'h00010000);

        // Handshake timeout
        ack_en = 1'b0;
        wait_tout(200, "timeout pulse");
        cmp("timeout req low", 32'(adc_req), 32'd0);
        cmp("timeout temp kept", temp_out, 32'h00010000);
        ack_en = 1'b1;
        samp_vals = '{16'd100, 16'd101, 16'd102, 16'd103};
        wait_valid(60, "post-timeout valid");
        cmp("post-timeout temp", temp_out, 32'd102);

        // Configuration frozen for a running burst
        wait_req_rise(40, "cfg burst start");
        repeat (2) @(negedge clk);
        cfg_we = 1'b1; cfg_tc_base = 32'd5;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_valid(40, "cfg burst valid");
        cmp("frozen base", calc_tc_base, 32'd1);
        cmp("frozen temp", temp_out, 32'd102);
        wait_valid(40, "new base valid");
        cmp("new base", calc_tc_base, 32'd5);
        cmp("new base temp", temp_out, 32'd106);

        // Abort during the third sample request
        for (int i = 0; i < 3; i++) wait_req_rise(40, "abort req rise");
        enable = 1'b0;
        @(negedge clk);
        cmp("abort req low", 32'(adc_req), 32'd0);
        cmp("abort not busy", 32'(busy), 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (temp_valid) n++;
        end
        cmp("abort no valid", 32'(n), 32'd0);
        cmp("abort temp kept", temp_out, 32'd106);
        enable = 1'b1;
        wait_valid(60, "re-enable valid");
        cmp("re-enable avg", 32'(calc_adc_data), 32'd101);
        cmp("re-enable temp", temp_out, 32'd106);

        // Stray acknowledge while idle-waiting
        @(posedge clk) #2 stray_req = 1'b1;
        @(posedge clk) #2 stray_req = 1'b0;
        wait_valid(40, "stray-ack valid");
        cmp("stray ignored avg", 32'(calc_adc_data), 32'd101);

        // Asynchronous reset mid-burst
        wait_req_rise(40, "reset burst start");
        repeat (2) @(negedge clk);
        @(posedge clk) #3 rst_n = 1'b0;
        #1;
        cmp("async rst temp_out", temp_out, 32'd0);
        cmp("async rst adc_req", 32'(adc_req), 32'd0);
        cmp("async rst busy", 32'(busy), 32'd0);
        cmp("async rst calc_adc", 32'(calc_adc_data), 32'd0);
        @(posedge clk) #3 rst_n = 1'b1;
        wait_valid(60, "post-reset valid");
        cmp("post-reset temp", temp_out, 32'd101);

`ifdef TEMP_ALARM_EN
        // Low alarm
        samp_vals = '{16'd49, 16'd50, 16'd51, 16'd52};
        @(negedge clk);
        cfg_we = 1'b1; cfg_tc_base = 32'd0; cfg_hi_thr = 32'd100; cfg_lo_thr = 32'd60;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_valid(60, "alarm_lo valid");
        cmp("low temp", temp_out, 32'd50);
        cmp("alarm_hi cleared", 32'(alarm_hi), 32'd0);
        cmp("alarm_lo set", 32'(alarm_lo), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
